// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, imem request handshake and IF/ID register,
// with a one-entry skid buffer for stalls and a drop state for branch redirects.
module if_fetch_stage #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PC_Stall,
  input  logic            IF_ID_Stall,
  input  logic            Branch_Taken,
  input  logic [XLEN-1:0] Branch_Target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [XLEN-1:0] IF_ID_Instr,
  output logic            IF_ID_Valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_addr;
  logic [XLEN-1:0] r_ifid_pc;
  logic [XLEN-1:0] r_ifid_instr;
  logic            r_ifid_valid;
  logic [XLEN-1:0] r_skid_pc;
  logic [XLEN-1:0] r_skid_instr;
  logic            r_skid_valid;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_req_addr_nxt;
  logic [XLEN-1:0] w_ifid_pc_nxt;
  logic [XLEN-1:0] w_ifid_instr_nxt;
  logic            w_ifid_valid_nxt;
  logic [XLEN-1:0] w_skid_pc_nxt;
  logic [XLEN-1:0] w_skid_instr_nxt;
  logic            w_skid_valid_nxt;
  logic            w_stall;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_stall    = PC_Stall | IF_ID_Stall;
  assign w_target   = Branch_Target & ALIGN_MASK;
  assign w_pc_plus4 = r_pc + XLEN'(4);

  assign imem_addr   = r_req_addr;
  assign IF_ID_PC    = r_ifid_pc;
  assign IF_ID_Instr = r_ifid_instr;
  assign IF_ID_Valid = r_ifid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_req_addr_nxt   = r_req_addr;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_valid_nxt = r_ifid_valid;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_valid_nxt = r_skid_valid;
    imem_req         = 1'b0;

    case (r_state)
      IDLE: begin
        w_state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready && !w_stall) begin
          w_ifid_pc_nxt    = r_pc;
          w_ifid_instr_nxt = imem_rdata;
          w_ifid_valid_nxt = 1'b1;
          w_pc_nxt         = w_pc_plus4;
          w_req_addr_nxt   = w_pc_plus4;
        end else if (imem_ready) begin
          // Stalled response is parked so the instruction is neither lost nor refetched.
          w_skid_pc_nxt    = r_pc;
          w_skid_instr_nxt = imem_rdata;
          w_skid_valid_nxt = 1'b1;
          w_state_nxt      = HOLD;
        end else if (!w_stall) begin
          w_ifid_instr_nxt = NOP_INSTR;
          w_ifid_valid_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (!w_stall) begin
          w_ifid_pc_nxt    = r_skid_pc;
          w_ifid_instr_nxt = r_skid_instr;
          w_ifid_valid_nxt = r_skid_valid;
          w_skid_valid_nxt = 1'b0;
          w_pc_nxt         = w_pc_plus4;
          w_req_addr_nxt   = w_pc_plus4;
          w_state_nxt      = FETCH;
        end
      end
      DROP: begin
        imem_req         = 1'b1;
        w_ifid_instr_nxt = NOP_INSTR;
        w_ifid_valid_nxt = 1'b0;
        if (imem_ready) begin
          w_req_addr_nxt = r_pc;
          w_state_nxt    = FETCH;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // A redirect wins; an in-flight request must still complete at its old address.
    if (Branch_Taken) begin
      w_pc_nxt         = w_target;
      w_ifid_instr_nxt = NOP_INSTR;
      w_ifid_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
      if ((r_state == FETCH || r_state == DROP) && !imem_ready) begin
        w_state_nxt = DROP;
      end else begin
        w_req_addr_nxt = w_target;
        w_state_nxt    = FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= NOP_INSTR;
      r_skid_valid <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: memory returns ~address as data, and every
// instruction loaded into IF/ID is matched against a queue of expected PCs.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        PC_Stall;
  logic        IF_ID_Stall;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ[$];

  if_fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .PC_Stall(PC_Stall),
    .IF_ID_Stall(IF_ID_Stall),
    .Branch_Taken(Branch_Taken),
    .Branch_Target(Branch_Target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .IF_ID_PC(IF_ID_PC),
    .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_Valid(IF_ID_Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data is only meaningful on a completing beat; anything else is poison.
  assign imem_rdata = (imem_req && imem_ready) ? ~imem_addr : 32'hDEAD_BEEF;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic stl, input logic br,
                               input logic [31:0] tgt, input logic expLoad,
                               input logic [31:0] expPc);
    @(negedge clk);
    imem_ready    = rdy;
    PC_Stall      = stl;
    IF_ID_Stall   = stl;
    Branch_Taken  = br;
    Branch_Target = tgt;
    if (expLoad) expQ.push_back(expPc);
  endtask

  // A fresh IF/ID load is any valid entry after an edge where no stall was applied.
  always @(posedge clk) begin
    logic [31:0] expPc;
    #1;
    if (!rst && IF_ID_Valid && !(PC_Stall | IF_ID_Stall)) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedLoad actual_pc=%h required=none", IF_ID_PC);
      end else begin
        expPc = expQ.pop_front();
        checkOutput("sbPc", IF_ID_PC, expPc);
        checkOutput("sbInstr", IF_ID_Instr, ~expPc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    PC_Stall = 1'b0;
    IF_ID_Stall = 1'b0;
    Branch_Taken = 1'b0;
    Branch_Target = '0;
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstValid", {31'd0, IF_ID_Valid}, 32'd0);
    checkOutput("rstInstr", IF_ID_Instr, NOP);
    checkOutput("rstPc", IF_ID_PC, 32'd0);
    checkOutput("rstReq", {31'd0, imem_req}, 32'd0);
    checkOutput("rstAddr", imem_addr, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    checkOutput("idleReq", {31'd0, imem_req}, 32'd0);

    applyStimulus(1, 0, 0, '0, 1, 32'h0);
    checkOutput("firstReq", {31'd0, imem_req}, 32'd1);
    checkOutput("firstAddr", imem_addr, 32'h0);
    applyStimulus(1, 0, 0, '0, 1, 32'h4);

    applyStimulus(0, 0, 0, '0, 0, '0);
    checkOutput("waitAddrA", imem_addr, 32'h8);
    applyStimulus(0, 0, 0, '0, 0, '0);
    checkOutput("waitAddrB", imem_addr, 32'h8);
    checkOutput("bubbleValid", {31'd0, IF_ID_Valid}, 32'd0);
    checkOutput("bubbleInstr", IF_ID_Instr, NOP);
    applyStimulus(1, 0, 0, '0, 1, 32'h8);
    checkOutput("waitAddrC", imem_addr, 32'h8);
    checkOutput("bubbleValid2", {31'd0, IF_ID_Valid}, 32'd0);
    applyStimulus(1, 0, 0, '0, 1, 32'hC);

    applyStimulus(1, 1, 0, '0, 0, '0);
    checkOutput("skidAddr", imem_addr, 32'h10);
    applyStimulus(1, 1, 0, '0, 0, '0);
    checkOutput("holdReq", {31'd0, imem_req}, 32'd0);
    checkOutput("holdPcA", IF_ID_PC, 32'hC);
    applyStimulus(1, 1, 0, '0, 0, '0);
    checkOutput("holdPcB", IF_ID_PC, 32'hC);
    checkOutput("holdValid", {31'd0, IF_ID_Valid}, 32'd1);
    applyStimulus(1, 0, 0, '0, 1, 32'h10);
    applyStimulus(1, 0, 0, '0, 1, 32'h14);
    checkOutput("afterSkidAddr", imem_addr, 32'h14);
    applyStimulus(1, 0, 0, '0, 1, 32'h18);
    applyStimulus(1, 0, 0, '0, 1, 32'h1C);

    applyStimulus(0, 0, 1, 32'h103, 0, '0);
    checkOutput("brAddr", imem_addr, 32'h20);
    applyStimulus(0, 0, 0, '0, 0, '0);
    checkOutput("dropAddrA", imem_addr, 32'h20);
    checkOutput("dropReq", {31'd0, imem_req}, 32'd1);
    checkOutput("dropValid", {31'd0, IF_ID_Valid}, 32'd0);
    applyStimulus(0, 0, 0, '0, 0, '0);
    checkOutput("dropAddrB", imem_addr, 32'h20);
    applyStimulus(1, 0, 0, '0, 0, '0);
    checkOutput("dropAddrC", imem_addr, 32'h20);
    applyStimulus(1, 0, 0, '0, 1, 32'h100);
    checkOutput("targetAddr", imem_addr, 32'h100);

    applyStimulus(1, 1, 0, '0, 0, '0);
    checkOutput("skid2Addr", imem_addr, 32'h104);
    applyStimulus(1, 1, 1, 32'h200, 0, '0);
    checkOutput("hold2Req", {31'd0, imem_req}, 32'd0);
    applyStimulus(1, 0, 0, '0, 1, 32'h200);
    checkOutput("holdBrAddr", imem_addr, 32'h200);
    checkOutput("holdBrValid", {31'd0, IF_ID_Valid}, 32'd0);

    applyStimulus(1, 0, 1, 32'hFFFF_FFFC, 0, '0);
    checkOutput("readyBrAddr", imem_addr, 32'h204);
    applyStimulus(1, 0, 0, '0, 1, 32'hFFFF_FFFC);
    checkOutput("topAddr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, '0, 1, 32'h0);
    checkOutput("wrapAddr", imem_addr, 32'h0);

    applyStimulus(0, 0, 1, 32'h300, 0, '0);
    checkOutput("drop2Entry", imem_addr, 32'h4);
    applyStimulus(0, 0, 0, '0, 0, '0);
    checkOutput("drop2Addr", imem_addr, 32'h4);
    checkOutput("drop2Req", {31'd0, imem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncReq", {31'd0, imem_req}, 32'd0);
    checkOutput("asyncAddr", imem_addr, 32'h0);
    checkOutput("asyncValid", {31'd0, IF_ID_Valid}, 32'd0);
    checkOutput("asyncInstr", IF_ID_Instr, NOP);
    checkOutput("asyncPc", IF_ID_PC, 32'h0);

    @(negedge clk);
    imem_ready = 1'b1;
    rst = 1'b0;
    checkOutput("idle2Req", {31'd0, imem_req}, 32'd0);
    applyStimulus(1, 0, 0, '0, 1, 32'h0);
    checkOutput("restartAddr", imem_addr, 32'h0);
    applyStimulus(1, 0, 0, '0, 1, 32'h4);
    applyStimulus(0, 0, 0, '0, 0, '0);
    repeat (3) @(negedge clk);
    checkOutput("queueDrained", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
